bombe_result_reporter: RTL and testbench

Consumer end of the bombe's candidate-setting output interface. It captures every rotor_valid pulse (rotor order plus initial positions) into a small FIFO. Each entry is then serialized as a 9-byte ASCII record over a byte-wide valid/ready stream, which feeds the UART transmitter so candidate settings can be read on the host. It never stalls the bombe; surplus pulses are dropped and flagged.

---
 rtl/bombe_result_reporter.sv | 167 ++++++++++++++++
 tb/tb_bombe_result_reporter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bombe_result_reporter.sv
// Bombe result reporter: buffers candidate rotor settings coming from the
// bombe and turns each one into a 9-byte ASCII line for the UART.
// The bombe is never stalled. A candidate that finds no room is dropped
// and the sticky overflow flag is raised.
module bombe_result_reporter #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [8:0]  rotor_select_in,
  input  logic [14:0] rotor_initial_in,
  input  logic        rotor_valid_in,
  output logic [7:0]  byte_out,
  output logic        byte_valid_out,
  input  logic        byte_ready_in,
  output logic        overflow_out,
  output logic [15:0] records_sent_out,
  output logic        busy_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_t;

  state_t        r_state;
  state_t        w_nextState;

  logic [23:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic [23:0]   r_record;
  logic [3:0]    r_idx;
  logic          r_overflow;
  logic [15:0]   r_recordsSent;

  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_handshake;
  logic          w_lastByte;
  logic [7:0]    w_char;

  // A rotor number 0..4 prints as '1'..'5'. Anything larger prints as '?'.
  function automatic logic [7:0] rotorChar(input logic [2:0] n);
    return (n > 3'd4) ? 8'h3F : (8'h31 + {5'd0, n});
  endfunction

  // A position 0..25 prints as 'A'..'Z'. Anything larger prints as '?'.
  function automatic logic [7:0] posChar(input logic [4:0] p);
    return (p > 5'd25) ? 8'h3F : (8'h41 + {3'd0, p});
  endfunction

  assign w_handshake = (r_state == ST_SEND) && byte_ready_in;
  assign w_lastByte  = (r_idx == 4'd8);
  // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
  assign w_push      = rotor_valid_in && ((r_count < CW'(FIFO_DEPTH)) || w_pop);
  assign w_drop      = rotor_valid_in && !w_push;

  // Next-state logic. IDLE pops the head as soon as the FIFO is non-empty.
  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_nextState = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_handshake && w_lastByte) begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FIFO storage. Reset clears only the pointers, so stale data here is never read.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {rotor_select_in, rotor_initial_in};
    end
  end

  // FIFO pointers and occupancy. The pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Record register and byte index. The index advances only on an accepted byte.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_record <= '0;
      r_idx    <= '0;
    end else if (w_pop) begin
      r_record <= r_mem[r_rdPtr];
      r_idx    <= '0;
    end else if (w_handshake && !w_lastByte) begin
      r_idx    <= r_idx + 4'd1;
    end
  end

  // Sticky drop flag and saturating count of completed records.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_overflow    <= 1'b0;
      r_recordsSent <= '0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      if (w_handshake && w_lastByte && (r_recordsSent != 16'hFFFF)) begin
        r_recordsSent <= r_recordsSent + 16'd1;
      end
    end
  end

  // Character selection for the current index.
  // The record is {select[23:15], initial[14:0]}.
  always_comb begin
    w_char = 8'h00;
    case (r_idx)
      4'd0:    w_char = rotorChar(r_record[23:21]);
      4'd1:    w_char = rotorChar(r_record[20:18]);
      4'd2:    w_char = rotorChar(r_record[17:15]);
      4'd3:    w_char = 8'h20;
      4'd4:    w_char = posChar(r_record[14:10]);
      4'd5:    w_char = posChar(r_record[9:5]);
      4'd6:    w_char = posChar(r_record[4:0]);
      4'd7:    w_char = 8'h0D;
      4'd8:    w_char = 8'h0A;
      default: w_char = 8'h00;
    endcase
  end

  assign byte_valid_out   = (r_state == ST_SEND);
  assign byte_out         = (r_state == ST_SEND) ? w_char : 8'h00;
  assign overflow_out     = r_overflow;
  assign records_sent_out = r_recordsSent;
  assign busy_out         = (r_count != '0) || (r_state == ST_SEND);

endmodule

// File: tb/tb_bombe_result_reporter.sv
// Testbench for bombe_result_reporter.
// Candidate settings are turned into their expected ASCII bytes from the
// record format. A monitor compares every accepted byte in order and checks
// that a byte is held stable while it is stalled.
module tb_bombe_result_reporter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [8:0]  rotor_select_in;
  logic [14:0] rotor_initial_in;
  logic        rotor_valid_in;
  logic [7:0]  byte_out;
  logic        byte_valid_out;
  logic        byte_ready_in = 1'b0;
  logic        overflow_out;
  logic [15:0] records_sent_out;
  logic        busy_out;

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  expQ[$];
  int          bytesSeen = 0;
  int          recExp = 0;
  int          readyMode = 0;
  int          patIdx = 0;
  logic        prevHold = 1'b0;
  logic [7:0]  prevByte = 8'h00;

  bombe_result_reporter #(.FIFO_DEPTH(8)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rotor_select_in(rotor_select_in),
    .rotor_initial_in(rotor_initial_in),
    .rotor_valid_in(rotor_valid_in),
    .byte_out(byte_out),
    .byte_valid_out(byte_valid_out),
    .byte_ready_in(byte_ready_in),
    .overflow_out(overflow_out),
    .records_sent_out(records_sent_out),
    .busy_out(busy_out)
  );

  // Free-running 100 MHz clock.
  always #5 clk_in = ~clk_in;

  // One comparison: count it, and report it if it fails.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the nine characters of a record, built from the field values.
  task automatic expectRecord(input int sel, input int init);
    int rotor[3];
    int pos[3];
    rotor[0] = sel / 64;
    rotor[1] = (sel / 8) % 8;
    rotor[2] = sel % 8;
    pos[0]   = init / 1024;
    pos[1]   = (init / 32) % 32;
    pos[2]   = init % 32;
    for (int k = 0; k < 3; k++) expQ.push_back((rotor[k] <= 4) ? 8'(49 + rotor[k]) : 8'h3F);
    expQ.push_back(8'h20);
    for (int k = 0; k < 3; k++) expQ.push_back((pos[k] <= 25) ? 8'(65 + pos[k]) : 8'h3F);
    expQ.push_back(8'h0D);
    expQ.push_back(8'h0A);
    recExp++;
  endtask

  // Raise rotor_valid_in for the next cycle and leave it high.
  // Consecutive calls therefore produce back-to-back pulses.
  task automatic applyStimulus(input logic [8:0] sel, input logic [14:0] init, input bit accepted);
    @(posedge clk_in); #1;
    rotor_select_in  = sel;
    rotor_initial_in = init;
    rotor_valid_in   = 1'b1;
    if (accepted) expectRecord(int'(sel), int'(init));
  endtask

  task automatic endPulse();
    @(posedge clk_in); #1;
    rotor_valid_in = 1'b0;
  endtask

  // Wait, with a cycle budget, until the design has nothing left to do.
  // Then confirm that every expected byte arrived.
  task automatic waitIdle(input int budget, input string tag);
    @(posedge clk_in);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_in);
      if (!busy_out) break;
    end
    checkOutput({tag, "_idle"}, 32'(busy_out), 32'd0);
    checkOutput({tag, "_pending"}, 32'(expQ.size()), 32'd0);
    checkOutput({tag, "_records"}, 32'(records_sent_out), 32'(recExp));
  endtask

  // Downstream ready generator.
  // Modes: 0 hold low, 1 hold high, 2 repeating 1-0-0-1, 3 random.
  initial begin
    forever begin
      @(posedge clk_in); #1;
      case (readyMode)
        0: byte_ready_in = 1'b0;
        1: byte_ready_in = 1'b1;
        2: begin
          byte_ready_in = ((patIdx % 4) == 0) || ((patIdx % 4) == 3);
          patIdx++;
        end
        default: byte_ready_in = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Stream monitor: every accepted byte must be the next expected one.
  // A stalled byte must stay valid and unchanged on the following cycle.
  always @(negedge clk_in) begin
    if (rst_in) begin
      prevHold = 1'b0;
    end else begin
      if (prevHold) begin
        checkOutput("hold_valid", 32'(byte_valid_out), 32'd1);
        checkOutput("hold_byte", 32'(byte_out), 32'(prevByte));
      end
      if (byte_valid_out && byte_ready_in) begin
        bytesSeen++;
        checkOutput("stream_expected", 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() != 0) checkOutput("stream_byte", 32'(byte_out), 32'(expQ.pop_front()));
      end
      prevHold = byte_valid_out && !byte_ready_in;
      prevByte = byte_out;
    end
  end

  // Directed sequence of test steps.
  initial begin
    int base;
    bit found;
    rst_in           = 1'b1;
    rotor_valid_in   = 1'b0;
    rotor_select_in  = '0;
    rotor_initial_in = '0;

    // Reset state.
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    checkOutput("rst_valid", 32'(byte_valid_out), 32'd0);
    checkOutput("rst_byte", 32'(byte_out), 32'd0);
    checkOutput("rst_overflow", 32'(overflow_out), 32'd0);
    checkOutput("rst_records", 32'(records_sent_out), 32'd0);
    checkOutput("rst_busy", 32'(busy_out), 32'd0);
    @(posedge clk_in); #1;
    rst_in    = 1'b0;
    readyMode = 1;
    repeat (2) @(posedge clk_in);

    // Single record: check the latency from the pulse to the first byte.
    applyStimulus(9'b000_001_010, 15'b00000_00001_11001, 1'b1);
    @(negedge clk_in);
    checkOutput("lat_cycleN", 32'(byte_valid_out), 32'd0);
    endPulse();
    @(negedge clk_in);
    checkOutput("lat_cycleN1", 32'(byte_valid_out), 32'd0);
    @(negedge clk_in);
    checkOutput("lat_cycleN2_valid", 32'(byte_valid_out), 32'd1);
    checkOutput("lat_cycleN2_byte", 32'(byte_out), 32'h31);
    waitIdle(100, "single");

    // Backpressure: ready follows the pattern 1-0-0-1.
    readyMode = 2;
    base = bytesSeen;
    applyStimulus(9'b000_001_010, 15'b00000_00001_11001, 1'b1);
    endPulse();
    waitIdle(200, "backpressure");
    checkOutput("backpressure_bytes", 32'(bytesSeen - base), 32'd9);

    // Out-of-range fields print '?'.
    readyMode = 1;
    applyStimulus(9'b000_101_010, 15'b00000_00001_11010, 1'b1);
    endPulse();
    waitIdle(100, "range");

    // Random candidates under random backpressure, including two back-to-back.
    readyMode = 3;
    for (int r = 0; r < 4; r++) begin
      applyStimulus(9'($urandom_range(0, 511)), 15'($urandom_range(0, 32767)), 1'b1);
      if (r != 1) endPulse();
    end
    waitIdle(600, "random");

    // Fill while stalled: one record in flight and eight in the FIFO.
    // Then push on the IDLE cycle that pops the full FIFO.
    readyMode = 0;
    repeat (2) @(posedge clk_in);
    for (int r = 0; r < 9; r++) applyStimulus(9'($urandom_range(0, 511)), 15'($urandom_range(0, 32767)), 1'b1);
    endPulse();
    @(negedge clk_in);
    checkOutput("full_no_overflow", 32'(overflow_out), 32'd0);
    checkOutput("full_busy", 32'(busy_out), 32'd1);
    readyMode = 1;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      if (byte_valid_out && byte_ready_in && byte_out == 8'h0A) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("full_last_byte_seen", 32'(found), 32'd1);
    applyStimulus(9'($urandom_range(0, 511)), 15'($urandom_range(0, 32767)), 1'b1);
    endPulse();
    @(negedge clk_in);
    checkOutput("pushpop_no_overflow", 32'(overflow_out), 32'd0);
    waitIdle(400, "pushpop");

    // Overflow: the tenth pulse arrives with no room and is dropped.
    readyMode = 0;
    repeat (2) @(posedge clk_in);
    for (int r = 0; r < 10; r++) applyStimulus(9'($urandom_range(0, 511)), 15'($urandom_range(0, 32767)), r < 9);
    endPulse();
    @(negedge clk_in);
    checkOutput("overflow_set", 32'(overflow_out), 32'd1);
    readyMode = 3;
    waitIdle(1200, "overflow");
    checkOutput("overflow_sticky", 32'(overflow_out), 32'd1);

    // Reset after byte 4 of a record, with a second candidate still buffered.
    readyMode = 1;
    repeat (2) @(posedge clk_in);
    base = bytesSeen;
    applyStimulus(9'b001_010_011, 15'b00010_00011_00100, 1'b1);
    applyStimulus(9'b010_011_100, 15'b00101_00110_00111, 1'b0);
    endPulse();
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk_in); #1;
      if (bytesSeen >= base + 5) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("midrec_progress", 32'(found), 32'd1);
    rst_in = 1'b1;
    expQ.delete();
    recExp = 0;
    @(posedge clk_in);
    @(negedge clk_in);
    checkOutput("midrst_valid", 32'(byte_valid_out), 32'd0);
    checkOutput("midrst_records", 32'(records_sent_out), 32'd0);
    checkOutput("midrst_overflow", 32'(overflow_out), 32'd0);
    checkOutput("midrst_busy", 32'(busy_out), 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    checkOutput("midrst_discarded", 32'(busy_out), 32'd0);
    applyStimulus(9'b100_000_011, 15'b11001_00000_01100, 1'b1);
    endPulse();
    waitIdle(100, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
